gcn_aggregate: RTL and testbench

GCN_AGGREGATE -- requirements
Module: gcn_aggregate

---
 rtl/gcn_aggregate.sv | 199 +++++++++++++++++++
 tb/tb_gcn_aggregate.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_aggregate.sv
// gcn_aggregate
// Graph-convolution aggregation followed by a per-node argmax.
//
// The block walks a COO edge list one edge per cycle. For every edge it
// adds each endpoint's row of the combination matrix into the other
// endpoint's accumulator row. It then scans the accumulated rows column by
// column and reports, for every node, the index of its largest class.
//
// Optional feature: define GCN_AGG_SELF_LOOP_EN to preload each accumulator
// row with the node's own combination row. This turns the aggregation into
// (adjacency + identity). Without the macro the accumulators start at zero.
// Latency and all other behaviour are the same in both builds.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   start           level request, sampled in IDLE
//   fm_wm_in        combination matrix [node][class], held stable during a run
//   coo_in          {src, dst} edge at coo_address (combinational read)
//   coo_address     registered edge index
//   done            results valid; held until start drops
//   edge_err        sticky: some edge referenced a node index out of range
//   max_addi_answer per-node argmax class index
module gcn_aggregate #(
    parameter int NUM_OF_NODES      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int NUM_OF_EDGES      = 6,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int ACC_WIDTH         = 20,
    parameter int NODE_BW           = $clog2(NUM_OF_NODES),
    parameter int COO_ADDR_BW       = $clog2(NUM_OF_EDGES),
    parameter int MAX_ADDRESS_WIDTH = $clog2(WEIGHT_COLS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DOT_PROD_WIDTH-1:0]    fm_wm_in [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1],
    input  logic [2*NODE_BW-1:0]         coo_in,
    output logic [COO_ADDR_BW-1:0]       coo_address,
    output logic                         done,
    output logic                         edge_err,
    output logic [MAX_ADDRESS_WIDTH-1:0] max_addi_answer [0:NUM_OF_NODES-1]
);

    localparam int SUM_W = ACC_WIDTH + 1;
    localparam int LIM_W = NODE_BW + 1;

    typedef enum logic [2:0] {IDLE, INIT, EDGE, ARGMAX, DONE} state_t;

    state_t state;
    state_t state_next;

    logic [ACC_WIDTH-1:0]         acc      [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
    logic [ACC_WIDTH-1:0]         acc_next [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
    logic [ACC_WIDTH-1:0]         max_val  [0:NUM_OF_NODES-1];
    logic [MAX_ADDRESS_WIDTH-1:0] idx      [0:NUM_OF_NODES-1];
    logic [ACC_WIDTH-1:0]         cand_val [0:NUM_OF_NODES-1];
    logic [MAX_ADDRESS_WIDTH-1:0] cand_idx [0:NUM_OF_NODES-1];
    logic [MAX_ADDRESS_WIDTH-1:0] col;

    logic [NODE_BW-1:0] src;
    logic [NODE_BW-1:0] dst;
    logic               edge_bad;
    logic               last_edge;
    logic               last_col;

    // Unsigned add that clamps at all-ones instead of wrapping.
    function automatic logic [ACC_WIDTH-1:0] sat_add(
        input logic [ACC_WIDTH-1:0]      a,
        input logic [DOT_PROD_WIDTH-1:0] b
    );
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + SUM_W'(b);
        return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
    endfunction

    assign src = coo_in[2*NODE_BW-1:NODE_BW];
    assign dst = coo_in[NODE_BW-1:0];

    // NODE_BW is rounded up, so an index can exceed the node count.
    assign edge_bad  = ({1'b0, src} >= LIM_W'(NUM_OF_NODES)) ||
                       ({1'b0, dst} >= LIM_W'(NUM_OF_NODES));
    assign last_edge = (coo_address == COO_ADDR_BW'(NUM_OF_EDGES - 1));
    assign last_col  = (col == MAX_ADDRESS_WIDTH'(WEIGHT_COLS - 1));

    // Accumulator update for the current edge. Testing dst before src
    // means a self-loop edge adds its row exactly once.
    always_comb begin
        for (int n = 0; n < NUM_OF_NODES; n++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
                acc_next[n][c] = acc[n][c];
                if (!edge_bad) begin
                    if (NODE_BW'(n) == dst)
                        acc_next[n][c] = sat_add(acc[n][c], fm_wm_in[src][c]);
                    else if (NODE_BW'(n) == src)
                        acc_next[n][c] = sat_add(acc[n][c], fm_wm_in[dst][c]);
                end
            end
        end
    end

    // One argmax step for every node. Only a strictly larger value moves
    // the index, so ties keep the lowest column.
    always_comb begin
        for (int n = 0; n < NUM_OF_NODES; n++) begin
            cand_val[n] = max_val[n];
            cand_idx[n] = idx[n];
            if (col == '0) begin
                cand_val[n] = acc[n][0];
                cand_idx[n] = '0;
            end else if (acc[n][col] > max_val[n]) begin
                cand_val[n] = acc[n][col];
                cand_idx[n] = col;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic. start only matters in IDLE and DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = INIT;
            INIT:                   state_next = EDGE;
            EDGE:    if (last_edge) state_next = ARGMAX;
            ARGMAX:  if (last_col)  state_next = DONE;
            DONE:    if (!start)    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs. done follows the next state, so it
    // rises on the same edge that enters DONE and falls on the edge that
    // leaves it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coo_address <= '0;
            done        <= 1'b0;
            edge_err    <= 1'b0;
            col         <= '0;
            for (int n = 0; n < NUM_OF_NODES; n++) begin
                max_addi_answer[n] <= '0;
                max_val[n]         <= '0;
                idx[n]             <= '0;
                for (int c = 0; c < WEIGHT_COLS; c++)
                    acc[n][c] <= '0;
            end
        end else begin
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start)
                        edge_err <= 1'b0;
                end
                INIT: begin
                    coo_address <= '0;
                    col         <= '0;
                    for (int n = 0; n < NUM_OF_NODES; n++) begin
                        for (int c = 0; c < WEIGHT_COLS; c++) begin
`ifdef GCN_AGG_SELF_LOOP_EN
                            acc[n][c] <= ACC_WIDTH'(fm_wm_in[n][c]);
`else
                            acc[n][c] <= '0;
`endif
                        end
                    end
                end
                EDGE: begin
                    for (int n = 0; n < NUM_OF_NODES; n++)
                        for (int c = 0; c < WEIGHT_COLS; c++)
                            acc[n][c] <= acc_next[n][c];
                    if (edge_bad)
                        edge_err <= 1'b1;
                    if (!last_edge)
                        coo_address <= coo_address + 1'b1;
                end
                ARGMAX: begin
                    for (int n = 0; n < NUM_OF_NODES; n++) begin
                        max_val[n] <= cand_val[n];
                        idx[n]     <= cand_idx[n];
                        if (last_col)
                            max_addi_answer[n] <= cand_idx[n];
                    end
                    if (!last_col)
                        col <= col + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_aggregate.sv
// tb_gcn_aggregate
// Self-checking bench for gcn_aggregate. Two instances share the clock,
// reset, start, matrix and edge table: one uses the default 20-bit
// accumulators, the other uses 16-bit accumulators so that saturation is
// reachable. The expected answers come from a sum-then-clip reference
// model. Honours GCN_AGG_SELF_LOOP_EN in the same way as the design.
module tb_gcn_aggregate;

    localparam int N  = 6;
    localparam int WC = 3;
    localparam int NE = 6;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] fm_tab   [0:N-1][0:WC-1];
    logic [2:0]  edge_src [0:7];
    logic [2:0]  edge_dst [0:7];

    logic [5:0]  coo_a;
    logic [5:0]  coo_b;
    logic [2:0]  addr_a;
    logic [2:0]  addr_b;
    logic        done_a;
    logic        done_b;
    logic        err_a;
    logic        err_b;
    logic [1:0]  ans_a [0:N-1];
    logic [1:0]  ans_b [0:N-1];

    logic [1:0]  exp_a [0:N-1];
    logic [1:0]  exp_b [0:N-1];
    logic        exp_err;

    int checks = 0;
    int errors = 0;

    assign coo_a = {edge_src[addr_a], edge_dst[addr_a]};
    assign coo_b = {edge_src[addr_b], edge_dst[addr_b]};

    gcn_aggregate dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fm_wm_in        (fm_tab),
        .coo_in          (coo_a),
        .coo_address     (addr_a),
        .done            (done_a),
        .edge_err        (err_a),
        .max_addi_answer (ans_a)
    );

    gcn_aggregate #(.ACC_WIDTH(16)) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fm_wm_in        (fm_tab),
        .coo_in          (coo_b),
        .coo_address     (addr_b),
        .done            (done_b),
        .edge_err        (err_b),
        .max_addi_answer (ans_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: each accumulator is the plain sum of the rows of its
    // neighbours (a self-edge counts once), clipped to the accumulator
    // range. The answer is the first column holding the row maximum.
    task automatic build_model();
        longint sums [0:N-1][0:WC-1];
        longint cap;
        longint best;
        longint v;
        int s;
        int d;
        bit found;
        for (int n = 0; n < N; n++)
            for (int c = 0; c < WC; c++) begin
`ifdef GCN_AGG_SELF_LOOP_EN
                sums[n][c] = longint'(fm_tab[n][c]);
`else
                sums[n][c] = 0;
`endif
            end
        exp_err = 1'b0;
        for (int e = 0; e < NE; e++) begin
            s = int'(edge_src[e]);
            d = int'(edge_dst[e]);
            if (s >= N || d >= N)
                exp_err = 1'b1;
            else
                for (int c = 0; c < WC; c++) begin
                    sums[d][c] += longint'(fm_tab[s][c]);
                    if (s != d)
                        sums[s][c] += longint'(fm_tab[d][c]);
                end
        end
        for (int w = 0; w < 2; w++) begin
            cap = (w == 0) ? 64'hFFFFF : 64'hFFFF;
            for (int n = 0; n < N; n++) begin
                best = -1;
                for (int c = 0; c < WC; c++) begin
                    v = (sums[n][c] > cap) ? cap : sums[n][c];
                    if (v > best) best = v;
                end
                found = 1'b0;
                for (int c = 0; c < WC; c++) begin
                    v = (sums[n][c] > cap) ? cap : sums[n][c];
                    if (!found && v == best) begin
                        found = 1'b1;
                        if (w == 0) exp_a[n] = 2'(c);
                        else        exp_b[n] = 2'(c);
                    end
                end
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " done"},     32'(done_a), 32'd0);
        check_val({tag, " edge_err"}, 32'(err_a),  32'd0);
        check_val({tag, " coo_addr"}, 32'(addr_a), 32'd0);
        check_val({tag, " sat_done"}, 32'(done_b), 32'd0);
        for (int n = 0; n < N; n++) begin
            check_val($sformatf("%s ans[%0d]", tag, n),     32'(ans_a[n]), 32'd0);
            check_val($sformatf("%s sat_ans[%0d]", tag, n), 32'(ans_b[n]), 32'd0);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int n = 0; n < N; n++) begin
            check_val($sformatf("%s ans[%0d]", tag, n),     32'(ans_a[n]), 32'(exp_a[n]));
            check_val($sformatf("%s sat_ans[%0d]", tag, n), 32'(ans_b[n]), 32'(exp_b[n]));
        end
        check_val({tag, " edge_err"},     32'(err_a), 32'(exp_err));
        check_val({tag, " sat_edge_err"}, 32'(err_b), 32'(exp_err));
    endtask

    // One full run with start held high throughout: latency, results,
    // done held while start stays high, then release and results held.
    task automatic applyStimulus(input string tag);
        int cycles;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        cycles = 0;
        while (!done_a && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_val({tag, " latency"},  32'(cycles), 32'd10);
        check_val({tag, " sat_done"}, 32'(done_b), 32'd1);
        checkOutput(tag);
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, " done_held"}, 32'(done_a), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, " done_drop"},     32'(done_a), 32'd0);
        check_val({tag, " sat_done_drop"}, 32'(done_b), 32'd0);
        checkOutput({tag, " idle"});
    endtask

    task automatic fill_edges(input logic [2:0] s, input logic [2:0] d);
        for (int e = 0; e < 8; e++) begin
            edge_src[e] = s;
            edge_dst[e] = d;
        end
    endtask

    task automatic fill_random(input bit big);
        for (int n = 0; n < N; n++)
            for (int c = 0; c < WC; c++)
                fm_tab[n][c] = big ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 20));
        for (int e = 0; e < 8; e++) begin
            edge_src[e] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            edge_dst[e] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int n = 0; n < N; n++)
            for (int c = 0; c < WC; c++)
                fm_tab[n][c] = 16'd0;
        fill_edges(3'd0, 3'd1);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] self-loop pattern");
        for (int n = 0; n < N; n++) begin
            fm_tab[n][0] = 16'd1;
            fm_tab[n][1] = 16'd2;
            fm_tab[n][2] = 16'd3;
        end
        fill_edges(3'd0, 3'd1);
        applyStimulus("selfloop");

        $display("[TB] tie pattern");
        for (int n = 0; n < N; n++)
            for (int c = 0; c < WC; c++)
                fm_tab[n][c] = 16'd0;
        fm_tab[0][0] = 16'd5;
        fm_tab[0][1] = 16'd5;
        fm_tab[0][2] = 16'd1;
        fill_edges(3'd0, 3'd0);
        applyStimulus("tie");

        $display("[TB] out-of-range edge");
        for (int n = 0; n < N; n++)
            for (int c = 0; c < WC; c++)
                fm_tab[n][c] = 16'(n * 3 + (c * 7) % 5);
        fill_edges(3'd0, 3'd1);
        edge_src[2] = 3'd7;
        edge_dst[2] = 3'd1;
        applyStimulus("range");

        $display("[TB] saturation");
        for (int n = 0; n < N; n++)
            for (int c = 0; c < WC; c++)
                fm_tab[n][c] = 16'd0;
        fm_tab[1][0] = 16'hF000;
        fm_tab[1][1] = 16'd0;
        fm_tab[1][2] = 16'd1;
        fill_edges(3'd0, 3'd1);
        applyStimulus("saturate");

        $display("[TB] random runs");
        for (int r = 0; r < 6; r++) begin
            fill_random(r[0]);
            applyStimulus($sformatf("random%0d", r));
        end

        $display("[TB] reset during edge phase");
        fm_tab[2][1] = 16'd40;
        fill_edges(3'd2, 3'd3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("post_reset idle done", 32'(done_a), 32'd0);
        check_val("post_reset idle addr", 32'(addr_a), 32'd0);
        fill_random(1'b0);
        applyStimulus("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
